rx_buf_demux: RTL and testbench

- Receive-side counterpart of the TX queue arbiter.
- Accepts 64-bit beats from the XGMII RX decode path, each frame tagged with a 2-bit class using the same codes as TX: 01 REQ, 10 MEM, 11 NET, 00 control/idle.
- Steers each frame into the request, memory or network RX queue.
- Admits a frame only when the target queue has room; otherwise drops the whole frame. Flags framing and overflow faults.

---
 rtl/rx_buf_demux_pkg.sv | 24 ++
 rtl/rx_class_sel.sv | 25 ++
 rtl/rx_buf_demux.sv | 197 +++++++++++++++++++
 tb/tb_rx_buf_demux.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_buf_demux_pkg.sv
// Shared definitions for the RX buffer demux: class codes, FSM encoding and
// default admission parameters (also used by the TX queue arbiter).
package rx_buf_demux_pkg;

  localparam logic [1:0] CLS_IDLE = 2'b00;
  localparam logic [1:0] CLS_REQ  = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [1:0] CLS_NET  = 2'b11;

  localparam int THRES_DEF     = 5;
  localparam int MAX_BEATS_DEF = 4;

  // Target one-hot bit positions.
  localparam int Q_REQ = 0;
  localparam int Q_MEM = 1;
  localparam int Q_NET = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_class_sel.sv
// Combinational frame-class decoder: class code -> target queue one-hot and
// that queue's free space. Idle/control class selects nothing with zero space.
module rx_class_sel
  import rx_buf_demux_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [3:0] reqq_space,
  input  logic [3:0] memq_space,
  input  logic [3:0] netq_space,
  output logic [2:0] tgt,
  output logic [3:0] space
);

  always_comb begin
    tgt   = '0;
    space = '0;
    case (cls)
      CLS_REQ: begin tgt[Q_REQ] = 1'b1; space = reqq_space; end
      CLS_MEM: begin tgt[Q_MEM] = 1'b1; space = memq_space; end
      CLS_NET: begin tgt[Q_NET] = 1'b1; space = netq_space; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_buf_demux.sv
// RX frame steering into request/memory/network queues with admission control
// and fault flagging. Optional per-class drop counters under RX_DROP_CNT_EN.
module rx_buf_demux
  import rx_buf_demux_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int THRES     = THRES_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic [1:0]        rx_class,
  input  logic [3:0]        memq_space,
  input  logic [3:0]        netq_space,
  input  logic [3:0]        reqq_space,
  output logic              memq_wr,
  output logic              netq_wr,
  output logic              reqq_wr,
  output logic [DATA_W-1:0] q_wdata,
  output logic              q_wlast,
  output logic              q_werr,
  output logic              memq_reset,
  output logic              netq_reset,
  output logic              reqq_reset,
  output logic              rx_drop,
  output logic              rx_overflow
`ifdef RX_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt_req,
  output logic [15:0]       drop_cnt_mem,
  output logic [15:0]       drop_cnt_net
`endif
);

  localparam int                CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [4:0]        THRES_L = 5'(THRES);

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [1:0]        cls_q, cls_nxt;

  logic [2:0]        sof_tgt, fwd_tgt;
  logic [3:0]        sof_space, fwd_space;

  logic [2:0]        wr_nxt;
  logic              wlast_nxt, werr_nxt, drop_nxt, ovf_nxt;

  logic [2:0]        wr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              wlast_p1, werr_p1, drop_p1, ovf_p1, qrst_p1;

  // New frames decode the live class; open frames use the latched one.
  rx_class_sel u_sof_sel (
    .cls        (rx_class),
    .reqq_space (reqq_space),
    .memq_space (memq_space),
    .netq_space (netq_space),
    .tgt        (sof_tgt),
    .space      (sof_space)
  );

  rx_class_sel u_fwd_sel (
    .cls        (cls_q),
    .reqq_space (reqq_space),
    .memq_space (memq_space),
    .netq_space (netq_space),
    .tgt        (fwd_tgt),
    .space      (fwd_space)
  );

  assign cnt_inc = cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cls_nxt   = cls_q;
    wr_nxt    = '0;
    wlast_nxt = 1'b0;
    werr_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    ovf_nxt   = 1'b0;
    if (rx_valid) begin
      if (rx_sof) begin
        // A SOF is admitted the same way regardless of state; an open frame is abandoned.
        ovf_nxt = (state == ST_FWD);
        if (sof_tgt == '0 || {1'b0, sof_space} < THRES_L) begin
          drop_nxt  = (sof_tgt != '0);
          state_nxt = rx_eof ? ST_IDLE : ST_DROP;
        end else begin
          wr_nxt  = sof_tgt;
          cls_nxt = rx_class;
          cnt_nxt = CNT_ONE;
          if (rx_eof) begin
            wlast_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_FWD;
          end
        end
      end else begin
        case (state)
          ST_FWD: begin
            if (fwd_space == '0) begin
              ovf_nxt   = 1'b1;
              state_nxt = rx_eof ? ST_IDLE : ST_DROP;
            end else begin
              wr_nxt  = fwd_tgt;
              cnt_nxt = cnt_inc;
              if (rx_eof) begin
                wlast_nxt = 1'b1;
                state_nxt = ST_IDLE;
              end else if (cnt_inc == CNT_MAX) begin
                wlast_nxt = 1'b1;
                werr_nxt  = 1'b1;
                ovf_nxt   = 1'b1;
                state_nxt = ST_DROP;
              end
            end
          end
          ST_DROP: if (rx_eof) state_nxt = ST_IDLE;
          default: ;
        endcase
      end
    end
    if (state_nxt != ST_FWD) cnt_nxt = '0;
  end

  // ---- p1: registered control and write outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cls_q    <= CLS_IDLE;
      wr_p1    <= '0;
      wdata_p1 <= '0;
      wlast_p1 <= 1'b0;
      werr_p1  <= 1'b0;
      drop_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
      qrst_p1  <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cls_q    <= cls_nxt;
      wr_p1    <= wr_nxt;
      wlast_p1 <= wlast_nxt;
      werr_p1  <= werr_nxt;
      drop_p1  <= drop_nxt;
      ovf_p1   <= ovf_nxt;
      qrst_p1  <= 1'b0;
      if (wr_nxt != '0) wdata_p1 <= rx_data;
    end
  end

  assign reqq_wr     = wr_p1[Q_REQ];
  assign memq_wr     = wr_p1[Q_MEM];
  assign netq_wr     = wr_p1[Q_NET];
  assign q_wdata     = wdata_p1;
  assign q_wlast     = wlast_p1;
  assign q_werr      = werr_p1;
  assign rx_drop     = drop_p1;
  assign rx_overflow = ovf_p1;
  assign reqq_reset  = qrst_p1;
  assign memq_reset  = qrst_p1;
  assign netq_reset  = qrst_p1;

`ifdef RX_DROP_CNT_EN
  logic [15:0] dcnt_req_p1, dcnt_mem_p1, dcnt_net_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_req_p1 <= '0;
      dcnt_mem_p1 <= '0;
      dcnt_net_p1 <= '0;
    end else if (drop_nxt) begin
      if (sof_tgt[Q_REQ]) dcnt_req_p1 <= sat_inc16(dcnt_req_p1);
      if (sof_tgt[Q_MEM]) dcnt_mem_p1 <= sat_inc16(dcnt_mem_p1);
      if (sof_tgt[Q_NET]) dcnt_net_p1 <= sat_inc16(dcnt_net_p1);
    end
  end

  assign drop_cnt_req = dcnt_req_p1;
  assign drop_cnt_mem = dcnt_mem_p1;
  assign drop_cnt_net = dcnt_net_p1;
`endif

endmodule

// File: tb/tb_rx_buf_demux.sv
// Self-checking bench for rx_buf_demux: directed scenarios plus random beats
// checked against a frame-level reference model.
module tb_rx_buf_demux;

  localparam int DATA_W    = 64;
  localparam int THRES     = 5;
  localparam int MAX_BEATS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic [1:0]        rx_class = 2'b00;
  logic [3:0]        memq_space = 4'd8, netq_space = 4'd8, reqq_space = 4'd8;
  logic              memq_wr, netq_wr, reqq_wr;
  logic [DATA_W-1:0] q_wdata;
  logic              q_wlast, q_werr, memq_reset, netq_reset, reqq_reset;
  logic              rx_drop, rx_overflow;
`ifdef RX_DROP_CNT_EN
  logic [15:0]       drop_cnt_req, drop_cnt_mem, drop_cnt_net;
`endif

  rx_buf_demux #(.DATA_W(DATA_W), .THRES(THRES), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_class(rx_class),
    .memq_space(memq_space), .netq_space(netq_space), .reqq_space(reqq_space),
    .memq_wr(memq_wr), .netq_wr(netq_wr), .reqq_wr(reqq_wr),
    .q_wdata(q_wdata), .q_wlast(q_wlast), .q_werr(q_werr),
    .memq_reset(memq_reset), .netq_reset(netq_reset), .reqq_reset(reqq_reset),
    .rx_drop(rx_drop), .rx_overflow(rx_overflow)
`ifdef RX_DROP_CNT_EN
    , .drop_cnt_req(drop_cnt_req), .drop_cnt_mem(drop_cnt_mem), .drop_cnt_net(drop_cnt_net)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: only "is an admitted frame open, to which class, how many beats".
  bit                m_fwd = 1'b0;
  logic [1:0]        m_tgt = 2'b00;
  int                m_n   = 0;
  int                mdc [4] = '{0, 0, 0, 0};
  logic [9:0]        exp_ctl;
  logic [DATA_W-1:0] exp_data = '0;

  // {reqq_wr, memq_wr, netq_wr, q_wlast, q_werr, rx_drop, rx_overflow, 3 queue resets}
  function automatic logic [9:0] obs_ctl();
    return {reqq_wr, memq_wr, netq_wr, q_wlast, q_werr, rx_drop, rx_overflow,
            reqq_reset, memq_reset, netq_reset};
  endfunction

  function automatic int space_of(input logic [1:0] c);
    case (c)
      2'b01:   return int'(reqq_space);
      2'b10:   return int'(memq_space);
      2'b11:   return int'(netq_space);
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] wr_of(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_fwd = 1'b0;
    m_n   = 0;
    for (int i = 0; i < 4; i++) mdc[i] = 0;
  endtask

  // Drive one beat, predict the registered response, advance one clock.
  task automatic step(input logic v, input logic s, input logic e,
                      input logic [1:0] c, input logic [DATA_W-1:0] d);
    logic [2:0] e_wr;
    logic       e_wl, e_we, e_dr, e_ov;
    rx_valid = v; rx_sof = s; rx_eof = e; rx_class = c; rx_data = d;
    e_wr = 3'b000; e_wl = 1'b0; e_we = 1'b0; e_dr = 1'b0; e_ov = 1'b0;
    if (v) begin
      if (s) begin
        if (m_fwd) e_ov = 1'b1;
        m_fwd = 1'b0;
        if (c != 2'b00) begin
          if (space_of(c) < THRES) begin
            e_dr = 1'b1;
            if (mdc[c] < 65535) mdc[c]++;
          end else begin
            e_wr = wr_of(c); exp_data = d; m_n = 1;
            if (e) e_wl = 1'b1;
            else begin m_fwd = 1'b1; m_tgt = c; end
          end
        end
      end else if (m_fwd) begin
        if (space_of(m_tgt) == 0) begin
          e_ov = 1'b1; m_fwd = 1'b0;
        end else begin
          e_wr = wr_of(m_tgt); exp_data = d; m_n++;
          if (e) begin
            e_wl = 1'b1; m_fwd = 1'b0;
          end else if (m_n == MAX_BEATS) begin
            e_wl = 1'b1; e_we = 1'b1; e_ov = 1'b1; m_fwd = 1'b0;
          end
        end
      end
    end
    exp_ctl = {e_wr, e_wl, e_we, e_dr, e_ov, 3'b000};
    @(posedge clk);
    #1;
  endtask

  task automatic set_space(input logic [3:0] r, input logic [3:0] m, input logic [3:0] n);
    reqq_space = r; memq_space = m; netq_space = n;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs_ctl() !== 10'b0000000_111 || q_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state ctl=%b data=%h want ctl=%b data=0", obs_ctl(), q_wdata, 10'b0000000_111);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs_ctl() !== 10'b0000000_111) begin
      n_fail++;
      $display("FAIL reset_release_hold ctl=%b want %b", obs_ctl(), 10'b0000000_111);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (obs_ctl() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_qrst_drop ctl=%b want %b", obs_ctl(), 10'b0);
    end
    model_reset();
`ifdef RX_DROP_CNT_EN
    n_tests++;
    if ({drop_cnt_req, drop_cnt_mem, drop_cnt_net} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_dropcnt got %h %h %h want 0", drop_cnt_req, drop_cnt_mem, drop_cnt_net);
    end
`endif
  endtask

  task automatic test_mem_frame();
    int nwr = 0;
    set_space(4'd8, 4'd8, 4'd8);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, i == 0, i == 2, 2'b10, 64'hA5A5_0000_0000_0000 + 64'(i));
      else       step(1'b0, 1'b0, 1'b0, 2'b00, '0);
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL mem_frame beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
      if (exp_ctl[9:7] != 3'b000) begin
        n_tests++;
        if (q_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL mem_frame_data beat%0d got %h want %h", i, q_wdata, exp_data);
        end
      end
      if (memq_wr) nwr++;
    end
    n_tests++;
    if (nwr != 3) begin
      n_fail++;
      $display("FAIL mem_frame_count got %0d want 3", nwr);
    end
  endtask

  task automatic test_drop();
    int ndrop = 0;
    set_space(4'd8, 4'd8, 4'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, i == 0, i == 2, 2'b11, 64'(i + 100));
      else       step(1'b0, 1'b0, 1'b0, 2'b00, '0);
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL drop beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
      if (rx_drop) ndrop++;
    end
    n_tests++;
    if (ndrop != 1) begin
      n_fail++;
      $display("FAIL drop_pulses got %0d want 1", ndrop);
    end
`ifdef RX_DROP_CNT_EN
    n_tests++;
    if (drop_cnt_net !== 16'(mdc[3])) begin
      n_fail++;
      $display("FAIL drop_cnt_net got %0d want %0d", drop_cnt_net, mdc[3]);
    end
`endif
  endtask

  task automatic test_overflow();
    int nwr = 0;
    int nerr = 0;
    set_space(4'd15, 4'd8, 4'd8);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i == 0, i == 5, 2'b01, 64'hC0DE_0000 + 64'(i));
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL overflow beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
      if (reqq_wr) nwr++;
      if (q_werr && q_wlast && rx_overflow) nerr++;
    end
    n_tests++;
    if (nwr != MAX_BEATS || nerr != 1) begin
      n_fail++;
      $display("FAIL overflow_count writes=%0d errs=%0d want %0d 1", nwr, nerr, MAX_BEATS);
    end
  endtask

  task automatic test_single();
    set_space(4'd15, 4'd8, 4'd8);
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      step(1'b1, 1'b1, 1'b1, 2'b01, 64'h1111);
      else if (i == 1) step(1'b1, 1'b1, 1'b1, 2'b10, 64'h2222);
      else             step(1'b0, 1'b0, 1'b0, 2'b00, '0);
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL single beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
      if (exp_ctl[9:7] != 3'b000) begin
        n_tests++;
        if (q_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL single_data beat%0d got %h want %h", i, q_wdata, exp_data);
        end
      end
    end
  endtask

  task automatic test_sof_mid();
    logic s, e;
    logic [1:0] c;
    set_space(4'd8, 4'd8, 4'd8);
    for (int i = 0; i < 5; i++) begin
      s = (i == 0 || i == 2);
      e = (i == 4);
      c = (i < 2) ? 2'b10 : 2'b11;
      step(1'b1, s, e, c, 64'hBEEF_0000 + 64'(i));
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL sof_mid beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
    end
  endtask

  task automatic test_space_zero();
    set_space(4'd8, 4'd8, 4'd8);
    for (int i = 0; i < 5; i++) begin
      netq_space = (i == 2) ? 4'd0 : 4'd8;
      step(1'b1, i == 0, i == 4, 2'b11, 64'(i + 7));
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL space_zero beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_space(4'd8, 4'd8, 4'd8);
    step(1'b1, 1'b1, 1'b0, 2'b10, 64'h5151);
    step(1'b1, 1'b0, 1'b0, 2'b10, 64'h5252);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (obs_ctl() !== 10'b0000000_111) begin
      n_fail++;
      $display("FAIL reset_mid_async ctl=%b want %b", obs_ctl(), 10'b0000000_111);
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (obs_ctl() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_release ctl=%b want %b", obs_ctl(), 10'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, i == 0, i == 1, 2'b01, 64'h7700 + 64'(i));
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL reset_mid_new beat%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
    end
  endtask

  function automatic logic [3:0] pick_space();
    case ($urandom_range(0, 5))
      0:       return 4'd0;
      1:       return 4'd3;
      2:       return 4'd4;
      3:       return 4'd5;
      4:       return 4'd8;
      default: return 4'd15;
    endcase
  endfunction

  task automatic test_random();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      set_space(pick_space(), pick_space(), pick_space());
      d = {$urandom, $urandom};
      step($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), d);
      n_tests++;
      if (obs_ctl() !== exp_ctl) begin
        n_fail++;
        $display("FAIL random step%0d ctl=%b want %b", i, obs_ctl(), exp_ctl);
      end
      if (exp_ctl[9:7] != 3'b000) begin
        n_tests++;
        if (q_wdata !== exp_data) begin
          n_fail++;
          $display("FAIL random_data step%0d got %h want %h", i, q_wdata, exp_data);
        end
      end
    end
`ifdef RX_DROP_CNT_EN
    n_tests++;
    if (drop_cnt_req !== 16'(mdc[1]) || drop_cnt_mem !== 16'(mdc[2]) || drop_cnt_net !== 16'(mdc[3])) begin
      n_fail++;
      $display("FAIL random_dropcnt got %0d %0d %0d want %0d %0d %0d",
               drop_cnt_req, drop_cnt_mem, drop_cnt_net, mdc[1], mdc[2], mdc[3]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mem_frame();
    test_drop();
    test_overflow();
    test_single();
    test_sof_mid();
    test_space_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
